// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Registered output stage behind the 32-bit ALU. It captures the result, the
//   op code and the qualified flags. A 2-entry skid buffer presents them to the
//   writeback stage over a valid/ready handshake. in_ready is registered and
//   does not depend combinationally on out_ready.
//   The block also keeps a sticky signed-overflow bit and counts retired
//   entries, meaning entries transferred on the output side.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   EMPTY | no entry held, out_valid = 0, in_ready = 1
//   ONE   | head register H valid, in_ready = 1
//   TWO   | H and skid register S valid, in_ready = 0
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_result, in_op    ALU result and op (op[1:0]: 00 and, 01 or, 10 add/sub)
//   in_cout/zero/set/ovf raw ALU flags
//   out_valid/out_ready downstream handshake
//   out_result, out_op  head entry
//   out_flags           {cout, zero, set, ovf} of the head entry (qualified)
//   ovf_sticky          sticky qualified overflow, ovf_clear clears it
//   op_count            wrapping count of output transfers
// -----------------------------------------------------------------------------
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [2:0]       in_op,
   input  logic             in_cout,
   input  logic             in_zero,
   input  logic             in_set,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_op,
   output logic [3:0]       out_flags,
   output logic             ovf_sticky,
   input  logic             ovf_clear,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;

   logic [WIDTH-1:0] r_h_result;
   logic [2:0]       r_h_op;
   logic [3:0]       r_h_flags;
   logic [WIDTH-1:0] r_s_result;
   logic [2:0]       r_s_op;
   logic [3:0]       r_s_flags;

   logic             r_ovf_sticky;
   logic [CNT_W-1:0] r_op_count;

   logic             w_acc;
   logic             w_ret;
   logic             w_is_arith;
   logic [3:0]       w_in_flags;
   logic             w_load_h_in;
   logic             w_load_h_s;
   logic             w_load_s;

   assign out_valid  = (r_state != ST_EMPTY);
   assign in_ready   = r_in_ready;
   assign w_acc      = in_valid & r_in_ready;
   assign w_ret      = out_valid & out_ready;

   // Carry and overflow only have meaning for add/sub. Logic ops leave
   // whatever the adder produced on those wires, so both are masked here.
   assign w_is_arith = (in_op[1:0] == 2'b10);
   assign w_in_flags = {in_cout & w_is_arith, in_zero, in_set, in_ovf & w_is_arith};

   always_comb begin
      w_state_nxt = r_state;
      w_load_h_in = 1'b0;
      w_load_h_s  = 1'b0;
      w_load_s    = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_load_h_in = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_acc && !w_ret) begin
               w_load_s    = 1'b1;
               w_state_nxt = ST_TWO;
            end else if (w_acc && w_ret) begin
               w_load_h_in = 1'b1;
            end else if (w_ret) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_ret) begin
               w_load_h_s  = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_EMPTY;
         r_in_ready   <= 1'b0;
         r_h_result   <= '0;
         r_h_op       <= '0;
         r_h_flags    <= '0;
         r_s_result   <= '0;
         r_s_op       <= '0;
         r_s_flags    <= '0;
         r_ovf_sticky <= 1'b0;
         r_op_count   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_TWO);

         if (w_load_h_in) begin
            r_h_result <= in_result;
            r_h_op     <= in_op;
            r_h_flags  <= w_in_flags;
         end else if (w_load_h_s) begin
            r_h_result <= r_s_result;
            r_h_op     <= r_s_op;
            r_h_flags  <= r_s_flags;
         end

         if (w_load_s) begin
            r_s_result <= in_result;
            r_s_op     <= in_op;
            r_s_flags  <= w_in_flags;
         end

         // A new overflow has priority over a clear in the same cycle.
         r_ovf_sticky <= (w_acc & w_in_flags[0]) | (r_ovf_sticky & ~ovf_clear);

         if (w_ret) begin
            r_op_count <= r_op_count + 1'b1;
         end
      end
   end

   assign out_result = r_h_result;
   assign out_op     = r_h_op;
   assign out_flags  = r_h_flags;
   assign ovf_sticky = r_ovf_sticky;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic [2:0]       in_op;
   logic             in_cout;
   logic             in_zero;
   logic             in_set;
   logic             in_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [2:0]       out_op;
   logic [3:0]       out_flags;
   logic             ovf_sticky;
   logic             ovf_clear;
   logic [CNT_W-1:0] op_count;

   alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_op      (in_op),
      .in_cout    (in_cout),
      .in_zero    (in_zero),
      .in_set     (in_set),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
      .out_flags  (out_flags),
      .ovf_sticky (ovf_sticky),
      .ovf_clear  (ovf_clear),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [2:0]       op;
      logic [3:0]       flags;
   } entry_t;

   entry_t q[$];
   int     vectors = 0;
   int     errs    = 0;
   int     pops    = 0;
   int     cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model of the capture: only add/sub (op[1:0] == 10) keeps carry and overflow.
   function automatic entry_t model(input logic [WIDTH-1:0] res, input logic [2:0] op,
                                    input logic c, input logic z, input logic s, input logic v);
      entry_t e;
      logic   arith;
      arith   = (op[1:0] == 2'b10);
      e.result = res;
      e.op     = op;
      e.flags  = {arith ? c : 1'b0, z, s, arith ? v : 1'b0};
      return e;
   endfunction

   // Output monitor: each valid head is compared with the scoreboard front.
   // The head is popped only when it is transferred, so a stalled head must match every cycle.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (q.size() == 0) begin
            vectors++;
            errs++;
            $error("FAIL sb_underflow: observed out_valid=1 with result %0h, expected no entry", out_result);
         end else begin
            chk("out_result", 64'(out_result), 64'(q[0].result));
            chk("out_op",     64'(out_op),     64'(q[0].op));
            chk("out_flags",  64'(out_flags),  64'(q[0].flags));
            if (out_ready) begin
               void'(q.pop_front());
               pops++;
            end
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] res, input logic [2:0] op,
                       input logic c, input logic z, input logic s, input logic v);
      bit done;
      done      = 0;
      in_result = res;
      in_op     = op;
      in_cout   = c;
      in_zero   = z;
      in_set    = s;
      in_ovf    = v;
      in_valid  = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(res, op, c, z, s, v));
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("send_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0 && !out_valid) done = 1;
      end
      if (!done) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int c0;
   int p0;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_result = '0;
      in_op     = '0;
      in_cout   = 1'b0;
      in_zero   = 1'b0;
      in_set    = 1'b0;
      in_ovf    = 1'b0;
      out_ready = 1'b0;
      ovf_clear = 1'b0;

      // Values held while reset is asserted.
      #12;
      chk("rst_in_ready",   64'(in_ready),   64'd0);
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_out_op",     64'(out_op),     64'd0);
      chk("rst_out_flags",  64'(out_flags),  64'd0);
      chk("rst_sticky",     64'(ovf_sticky), 64'd0);
      chk("rst_op_count",   64'(op_count),   64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Streaming: and, add, sub with out_ready held high.
      out_ready = 1'b1;
      c0 = cyc;
      p0 = pops;
      send(32'h0000_0005, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      send(32'd10,        3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      send(32'd0,         3'b110, 1'b1, 1'b1, 1'b0, 1'b0);
      drain();
      chk("stream_cycles", 64'(cyc - c0),  64'd4);
      chk("stream_pops",   64'(pops - p0), 64'd3);
      chk("stream_count",  64'(op_count),  64'd3);

      // Reset mid-stream while both entries are held.
      out_ready = 1'b0;
      send(32'hAAAA_0001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      send(32'hAAAA_0002, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("two_in_ready", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid",  64'(out_valid),  64'd0);
      chk("midrst_in_ready",   64'(in_ready),   64'd0);
      chk("midrst_op_count",   64'(op_count),   64'd0);
      chk("midrst_out_result", 64'(out_result), 64'd0);
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_rel_in_ready", 64'(in_ready),  64'd1);
      chk("midrst_rel_valid",    64'(out_valid), 64'd0);

      // Back-pressure: A and B fill the buffer, C waits and is accepted after the stall clears.
      out_ready = 1'b0;
      p0 = pops;
      send(32'hA, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
      send(32'hB, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      in_result = 32'hC;
      in_op     = 3'b001;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready",   64'(in_ready),   64'd0);
         chk("bp_head_held",  64'(out_result), 64'hA);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'hC, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();
      chk("bp_pops",  64'(pops - p0), 64'd3);
      chk("bp_count", 64'(op_count),  64'd3);

      // Overflow qualification.
      send(32'h8000_0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovf_sticky_set", 64'(ovf_sticky),   64'd1);
      chk("ovf_flag_add",   64'(out_flags[0]), 64'd1);
      send(32'hFFFF_FFFF, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("or_flags_cout", 64'(out_flags[3]), 64'd0);
      chk("or_flags_ovf",  64'(out_flags[0]), 64'd0);
      drain();

      // Clear, then a clear racing an accepted overflowing sub.
      ovf_clear = 1'b1;
      @(posedge clk);
      #1;
      ovf_clear = 1'b0;
      chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
      ovf_clear = 1'b1;
      send(32'h7FFF_FFFF, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
      ovf_clear = 1'b0;
      chk("sticky_race_set_wins", 64'(ovf_sticky), 64'd1);
      drain();
      ovf_clear = 1'b1;
      @(posedge clk);
      #1;
      ovf_clear = 1'b0;
      chk("sticky_clear_alone", 64'(ovf_sticky), 64'd0);

      // Counter wrap with a 4-bit counter: 16 retires wrap to 0, the 17th gives 1.
      do_reset();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_no_count", 64'(op_count), 64'd0);
      for (int k = 0; k < 16; k++) begin
         send(32'(k * 3 + 1), 3'(k % 8), k[0], k[1], k[2], k[3]);
      end
      drain();
      chk("wrap_16", 64'(op_count), 64'd0);
      send(32'h1234_5678, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
      drain();
      chk("wrap_17", 64'(op_count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
